uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning the serial bit rate.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port rxd, input, 1 bit: asynchronous serial line (UART_RXD), idle high.
REQ-006 SHALL have port rd, input, 1 bit: consumer acknowledge; a 1-cycle pulse pops the held byte.
REQ-007 SHALL have port data, output, 8 bits: last received byte, LSB first on the line.
REQ-008 SHALL have port valid, output, 1 bit: high while data holds an unread byte.
REQ-009 SHALL have port frame_err, output, 1 bit: sticky; stop bit sampled low.
REQ-010 SHALL have port overrun, output, 1 bit: sticky; a byte completed while valid was high.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL pass rxd through a 2-flop synchronizer; all decisions use the synchronized value rxs, giving 2 cycles latency.
REQ-013 SHALL use integer CLKS_PER_BIT = CLK_FREQ/BAUD (truncated), which gives 434 at the defaults, and HALF = CLKS_PER_BIT/2.
REQ-014 SHALL use the FSM states IDLE, START, DATA and STOP, with one cycle counter cnt and a 3-bit bit index idx.
REQ-015 IDLE: SHALL go to START with cnt=0 when rxs==0; otherwise it SHALL stay in IDLE.
REQ-016 START: when cnt reaches HALF-1, SHALL go to DATA if rxs==0, or back to IDLE if rxs==1 (glitch reject, no flags touched); cnt SHALL restart at 0.
REQ-017 DATA: at cnt==CLKS_PER_BIT-1, SHALL sample rxs into shift bit idx (LSB first) and clear cnt; after idx==7 it SHALL go to STOP.
REQ-018 STOP: at cnt==CLKS_PER_BIT-1, SHALL sample rxs and return to IDLE in the same cycle.
REQ-019 Stop sample==1 and valid==0: SHALL load data with the shift register and set valid on the next edge.
REQ-020 Stop sample==1 and valid==1: SHALL discard the new byte, set overrun, and leave data unchanged.
REQ-021 Stop sample==0: SHALL set frame_err and discard the byte with valid unchanged; IDLE then waits for rxs==1 before accepting a new start (break handling).
REQ-022 rd while valid==1: SHALL clear valid on the next edge.
REQ-023 rd while valid==0: SHALL be ignored.
REQ-024 rd in the same cycle a byte completes with valid==1: rd SHALL take priority, the new byte SHALL load, valid SHALL stay 1, and overrun SHALL not be set.
REQ-025 rd SHALL also clear frame_err and overrun on the next edge; an error event in that same cycle SHALL win and keep the flag set.
REQ-026 SHALL size cnt as clog2(CLKS_PER_BIT) bits, and SHALL never let cnt wrap past CLKS_PER_BIT-1.
REQ-027 SHALL register all outputs; there SHALL be no combinational path from rxd or rd to any output.

Reset
REQ-028 When rst_n==0 at a rising clk edge: state SHALL be IDLE; cnt, idx, shift, data, valid, frame_err, overrun and busy SHALL be 0; synchronizer flops SHALL be 1.
REQ-029 Reset mid-frame SHALL abort the frame with no flag set; the remaining bits of that frame SHALL be treated as line activity (a low bit may start a new frame and end in frame_err, which is acceptable).

Structure
REQ-030 A shared package/include uart_pkg SHALL hold the FSM state encoding (2 bits: IDLE=0, START=1, DATA=2, STOP=3) and the CLKS_PER_BIT/HALF derivation, for reuse by a future uart_tx.
REQ-031 One sub-module, uart_sync (2-flop synchronizer, reset value 1), SHALL be instantiated; everything else SHALL be inline.

Verification
All scenarios use CLK_FREQ=800, BAUD=100, so CLKS_PER_BIT=8 and HALF=4.
REQ-032 Frame 0xA5 with a good stop bit -> valid rises about 2+4+8*8+8 cycles after the start edge, data=0xA5, frame_err=0; a rd pulse then clears valid.
REQ-033 Low glitch of 2 cycles on an idle line -> FSM returns to IDLE; valid, frame_err and overrun stay 0; busy pulses only.
REQ-034 Frame 0x3C with stop bit driven 0 -> frame_err=1, valid=0; a following good frame 0x55 (after line high) -> data=0x55, valid=1.
REQ-035 Two back-to-back frames 0x11 then 0x22 without rd -> data=0x11, overrun=1; repeat with rd issued in the exact completion cycle of 0x22 -> data=0x22, valid=1, overrun=0.
REQ-036 rst_n low for 1 cycle during bit 4 of frame 0xFF -> all outputs 0 next cycle, busy=0, and no valid from the aborted frame.

Source files
------------

// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state encoding and bit-timing derivation.
// Intended for reuse by both the receiver and a future transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic int clks_per_bit(int clk_freq, int baud);
    return clk_freq / baud;
  endfunction

  function automatic int half_bit(int cpb);
    return cpb / 2;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle (1).
// Ports: clk, rst_n (sync, active-low), d (async in), q (synchronized out).
module uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] s_q;
  logic [1:0] s_d;

  always_comb begin
    s_d = {s_q[0], d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q <= 2'b11;
    end else begin
      s_q <= s_d;
    end
  end

  assign q = s_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, single held byte with sticky error flags.
// Ports: clk, rst_n, rxd, rd -> data, valid, frame_err, overrun, busy.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  input  logic       rd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF = half_bit(CPB);
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  logic rxs;

  uart_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rxd),
    .q    (rxs)
  );

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          fe_q, fe_d;
  logic          ovr_q, ovr_d;
  logic          busy_q, busy_d;
  logic          brk_q, brk_d;
  logic          done;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    brk_d   = brk_q;
    done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // After a framing error the line must return high
        // before a new start bit is accepted.
        if (brk_q) begin
          if (rxs) brk_d = 1'b0;
        end else if (!rxs) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d[idx_q] = rxs;
          cnt_d          = '0;
          idx_d          = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          done    = 1'b1;
          if (!rxs) brk_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = fe_q;
    ovr_d   = ovr_q;
    busy_d  = (state_d != IDLE);

    if (rd) begin
      valid_d = 1'b0;
      fe_d    = 1'b0;
      ovr_d   = 1'b0;
    end

    // A pop in the completion cycle frees the slot for the new byte.
    if (done) begin
      if (rxs) begin
        if (!valid_q || rd) begin
          data_d  = shift_q;
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else begin
        fe_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
      brk_q   <= brk_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = fe_q;
  assign overrun   = ovr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLK_FREQ=800, BAUD=100.
// Frame-level reference model plus directed literal checks.
module tb_uart_rx;

  localparam int CPB  = 8;
  localparam int HALF = 4;
  // start edge -> sync(2) -> IDLE exit(1) -> half bit -> 8 data + stop
  localparam int LAT  = 3 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(
    .CLK_FREQ(800),
    .BAUD    (100)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxd      (rxd),
    .rd       (rd),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t0;
    int         tend;
    logic [7:0] b;
    logic       stop;
    bit         frame;
  } rec_t;

  rec_t recs[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] m_data;
  logic       m_valid, m_fe, m_ovr, m_busy;
  bit         m_on = 1'b0;

  int  rise_cyc = 0;
  int  busy_cnt = 0;
  logic valid_prev = 1'b0;

  function automatic void chk(string nm, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endfunction

  // Reference model: advances once per rising edge using pre-edge inputs.
  always @(posedge clk) begin
    logic rd_s;
    logic rst_s;
    logic [7:0] nd;
    logic nv, nf, no, nb;
    rd_s  = rd;
    rst_s = rst_n;
    cyc   = cyc + 1;
    if (!rst_s) begin
      m_data  = 8'h00;
      m_valid = 1'b0;
      m_fe    = 1'b0;
      m_ovr   = 1'b0;
      m_busy  = 1'b0;
      recs.delete();
      m_on    = 1'b1;
    end else begin
      nd = m_data;
      nv = m_valid;
      nf = rd_s ? 1'b0 : m_fe;
      no = rd_s ? 1'b0 : m_ovr;
      if (rd_s && m_valid) nv = 1'b0;
      nb = 1'b0;
      foreach (recs[i]) begin
        if (recs[i].frame && cyc == recs[i].t0 + LAT) begin
          if (recs[i].stop) begin
            if (!m_valid || rd_s) begin
              nd = recs[i].b;
              nv = 1'b1;
            end else begin
              no = 1'b1;
            end
          end else begin
            nf = 1'b1;
          end
        end
        if (cyc >= recs[i].t0 + 3 && cyc < recs[i].tend) nb = 1'b1;
      end
      for (int i = recs.size() - 1; i >= 0; i--) begin
        if (cyc >= recs[i].tend) recs.delete(i);
      end
      m_data  = nd;
      m_valid = nv;
      m_fe    = nf;
      m_ovr   = no;
      m_busy  = nb;
    end
  end

  always @(negedge clk) begin
    if (valid && !valid_prev) rise_cyc = cyc;
    valid_prev = valid;
    if (busy) busy_cnt = busy_cnt + 1;
    if (m_on) begin
      chk("data", data, m_data);
      chk("valid", {7'b0, valid}, {7'b0, m_valid});
      chk("frame_err", {7'b0, frame_err}, {7'b0, m_fe});
      chk("overrun", {7'b0, overrun}, {7'b0, m_ovr});
      chk("busy", {7'b0, busy}, {7'b0, m_busy});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd_pulse();
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
  endtask

  task automatic glitch(output int t0);
    rec_t r;
    @(posedge clk);
    #1;
    t0 = cyc;
    rxd = 1'b0;
    r = '{t0, t0 + 3 + HALF, 8'h00, 1'b1, 1'b0};
    recs.push_back(r);
    tick(2);
    rxd = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop,
                      input int rst_bit, input bit rd_done,
                      output int t0);
    rec_t r;
    @(posedge clk);
    #1;
    t0 = cyc;
    rxd = 1'b0;
    r = '{t0, t0 + LAT, b, stop, 1'b1};
    recs.push_back(r);
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      if (i == rst_bit) begin
        tick(3);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("rst_valid", {7'b0, valid}, 8'h00);
        chk("rst_busy", {7'b0, busy}, 8'h00);
        chk("rst_data", data, 8'h00);
        chk("rst_fe", {7'b0, frame_err}, 8'h00);
        chk("rst_ovr", {7'b0, overrun}, 8'h00);
        tick(CPB - 4);
      end else begin
        tick(CPB);
      end
    end
    rxd = stop;
    if (rd_done) begin
      tick(CPB - 2);
      rd = 1'b1;
      tick(1);
      rd = 1'b0;
      tick(1);
    end else begin
      tick(CPB);
    end
    rxd = 1'b1;
  endtask

  initial begin
    int t0;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    chk("init_valid", {7'b0, valid}, 8'h00);
    chk("init_busy", {7'b0, busy}, 8'h00);
    chk("init_data", data, 8'h00);

    send(8'hA5, 1'b1, -1, 1'b0, t0);
    chk("a5_data", data, 8'hA5);
    chk("a5_valid", {7'b0, valid}, 8'h01);
    chk("a5_fe", {7'b0, frame_err}, 8'h00);
    chk("a5_latency", 8'(rise_cyc - t0), 8'd79);
    rd_pulse();
    chk("a5_rd_clear", {7'b0, valid}, 8'h00);

    tick(5);
    busy_cnt = 0;
    glitch(t0);
    tick(12);
    chk("gl_busy_cycles", 8'(busy_cnt), 8'd4);
    chk("gl_valid", {7'b0, valid}, 8'h00);
    chk("gl_fe", {7'b0, frame_err}, 8'h00);
    chk("gl_ovr", {7'b0, overrun}, 8'h00);

    send(8'h3C, 1'b0, -1, 1'b0, t0);
    tick(4);
    chk("bad_fe", {7'b0, frame_err}, 8'h01);
    chk("bad_valid", {7'b0, valid}, 8'h00);
    tick(5);
    send(8'h55, 1'b1, -1, 1'b0, t0);
    chk("55_data", data, 8'h55);
    chk("55_valid", {7'b0, valid}, 8'h01);
    chk("55_fe_sticky", {7'b0, frame_err}, 8'h01);
    rd_pulse();
    chk("55_rd_valid", {7'b0, valid}, 8'h00);
    chk("55_rd_fe", {7'b0, frame_err}, 8'h00);

    tick(3);
    send(8'h11, 1'b1, -1, 1'b0, t0);
    send(8'h22, 1'b1, -1, 1'b0, t0);
    chk("ovr_data", data, 8'h11);
    chk("ovr_flag", {7'b0, overrun}, 8'h01);
    chk("ovr_valid", {7'b0, valid}, 8'h01);
    rd_pulse();
    chk("ovr_rd_clear", {7'b0, overrun}, 8'h00);

    tick(3);
    send(8'h11, 1'b1, -1, 1'b0, t0);
    send(8'h22, 1'b1, -1, 1'b1, t0);
    chk("rdwin_data", data, 8'h22);
    chk("rdwin_valid", {7'b0, valid}, 8'h01);
    chk("rdwin_ovr", {7'b0, overrun}, 8'h00);

    tick(5);
    send(8'hFF, 1'b1, 4, 1'b0, t0);
    tick(100);
    chk("abort_valid", {7'b0, valid}, 8'h00);
    chk("abort_busy", {7'b0, busy}, 8'h00);
    chk("abort_data", data, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
